// File: rtl/npc_mc_ctrl.sv
// ----------------------------------------------------------------------------
// npc_mc_ctrl
//   Multi-cycle core sequencer for the NPC. Walks each instruction through
//   fetch, decode, an optional load/store access and write-back, using level
//   req / pulse done handshakes with the IFU and LSU. Emits one-cycle commit
//   strobes, counts retired instructions and parks in a halt state on ebreak.
//
// Optional feature macro: CTRL_TIMEOUT_EN
//   Defined   : watchdog on the IF and LS waits; expiry parks the core in S_ERR.
//   Undefined : IF/LS wait forever, S_ERR is unreachable, bus_err is tied 0.
//
// Parameters
//   CNT_W        width of the retired-instruction counter
//   TIMEOUT_CYC  watchdog limit in cycles (only used with CTRL_TIMEOUT_EN)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   ifu_done     fetch complete (looked at only in S_IF)
//   idu_is_ls    decoded instruction is a load/store (looked at in S_ID)
//   idu_rd_wen   decoded instruction writes rd (stable S_ID..S_WB)
//   idu_ebreak   decoded instruction is ebreak (looked at in S_ID)
//   lsu_done     memory access complete (looked at only in S_LS)
//   ifu_req      fetch request, high for all of S_IF
//   lsu_req      memory request, high for all of S_LS
//   reg_write    RF write enable pulse in S_WB
//   pc_update    PC commit pulse in S_WB
//   halted       high in S_HALT
//   bus_err      high in S_ERR
//   state_o      current state code
//   instret      retired-instruction count
//
// state  | code | meaning
// S_RST  | 000  | in / just out of reset, all outputs quiet
// S_IF   | 001  | fetch: ifu_req held until ifu_done
// S_ID   | 011  | decode: pick halt, memory access or write-back
// S_LS   | 010  | memory access: lsu_req held until lsu_done
// S_WB   | 110  | write-back / commit, one cycle per retired instruction
// S_HALT | 100  | ebreak seen, terminal until reset
// S_ERR  | 111  | watchdog expired, terminal until reset
// ----------------------------------------------------------------------------
module npc_mc_ctrl #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ifu_done,
    input  logic             idu_is_ls,
    input  logic             idu_rd_wen,
    input  logic             idu_ebreak,
    input  logic             lsu_done,
    output logic             ifu_req,
    output logic             lsu_req,
    output logic             reg_write,
    output logic             pc_update,
    output logic             halted,
    output logic             bus_err,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_RST  = 3'b000,
        S_IF   = 3'b001,
        S_ID   = 3'b011,
        S_LS   = 3'b010,
        S_WB   = 3'b110,
        S_HALT = 3'b100,
        S_ERR  = 3'b111
    } state_t;

    state_t state;
    state_t stateNext;
    logic   wdogHit;

`ifdef CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] wdog;

    // Counts cycles spent waiting in S_IF / S_LS. Any state change (including
    // entry into S_IF / S_LS) restarts it from 0, so the first wait cycle sees 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog <= '0;
        end else if ((state == S_IF || state == S_LS) && stateNext == state) begin
            wdog <= wdog + 1'b1;
        end else begin
            wdog <= '0;
        end
    end

    assign wdogHit = (wdog == TO_W'(TIMEOUT_CYC));
`else
    // Keeps the timeout parameter referenced in builds without the watchdog.
    logic unusedTimeoutCfg;
    assign unusedTimeoutCfg = |TIMEOUT_CYC;
    assign wdogHit          = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RST;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        ifu_req   = 1'b0;
        lsu_req   = 1'b0;
        reg_write = 1'b0;
        pc_update = 1'b0;
        halted    = 1'b0;
        bus_err   = 1'b0;
        case (state)
            S_RST: begin
                stateNext = S_IF;
            end
            S_IF: begin
                ifu_req = 1'b1;
                // A done arriving on the expiry cycle still wins.
                if (ifu_done) begin
                    stateNext = S_ID;
                end else if (wdogHit) begin
                    stateNext = S_ERR;
                end
            end
            S_ID: begin
                if (idu_ebreak) begin
                    stateNext = S_HALT;
                end else if (idu_is_ls) begin
                    stateNext = S_LS;
                end else begin
                    stateNext = S_WB;
                end
            end
            S_LS: begin
                lsu_req = 1'b1;
                if (lsu_done) begin
                    stateNext = S_WB;
                end else if (wdogHit) begin
                    stateNext = S_ERR;
                end
            end
            S_WB: begin
                pc_update = 1'b1;
                reg_write = idu_rd_wen;
                stateNext = S_IF;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_ERR: begin
`ifdef CTRL_TIMEOUT_EN
                bus_err = 1'b1;
`endif
            end
            default: begin
                // Unused code 101 recovers through the reset state.
                stateNext = S_RST;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= '0;
        end else if (state == S_WB) begin
            instret <= instret + CNT_W'(1);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_npc_mc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_npc_mc_ctrl
//   Directed bench for npc_mc_ctrl. The stimulus process walks instructions
//   through the sequencer and, for each one it expects to retire, pushes the
//   expected commit (reg_write value, instret before the increment) into a
//   queue. A monitor pops and compares on every pc_update strobe.
//   Build with CTRL_TIMEOUT_EN defined to also exercise the watchdog.
// ----------------------------------------------------------------------------
module tb_npc_mc_ctrl;

    localparam int CNT_W       = 4;
    localparam int TIMEOUT_CYC = 8;

    localparam logic [2:0] ST_RST  = 3'b000;
    localparam logic [2:0] ST_IF   = 3'b001;
    localparam logic [2:0] ST_ID   = 3'b011;
    localparam logic [2:0] ST_LS   = 3'b010;
    localparam logic [2:0] ST_WB   = 3'b110;
    localparam logic [2:0] ST_HALT = 3'b100;
`ifdef CTRL_TIMEOUT_EN
    localparam logic [2:0] ST_ERR  = 3'b111;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ifu_done = 1'b0;
    logic             idu_is_ls = 1'b0;
    logic             idu_rd_wen = 1'b0;
    logic             idu_ebreak = 1'b0;
    logic             lsu_done = 1'b0;
    logic             ifu_req;
    logic             lsu_req;
    logic             reg_write;
    logic             pc_update;
    logic             halted;
    logic             bus_err;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] instret;

    int passCnt  = 0;
    int totalCnt = 0;

    logic [CNT_W-1:0] expInstret = '0;
    logic [CNT_W:0]   expQ[$];

    npc_mc_ctrl #(
        .CNT_W      (CNT_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ifu_done  (ifu_done),
        .idu_is_ls (idu_is_ls),
        .idu_rd_wen(idu_rd_wen),
        .idu_ebreak(idu_ebreak),
        .lsu_done  (lsu_done),
        .ifu_req   (ifu_req),
        .lsu_req   (lsu_req),
        .reg_write (reg_write),
        .pc_update (pc_update),
        .halted    (halted),
        .bus_err   (bus_err),
        .state_o   (state_o),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) begin
            passCnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Commit monitor: every pc_update strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (pc_update) begin
                if (expQ.size() == 0) begin
                    totalCnt++;
                    $display("FAIL unexpected_commit: got pc_update=1, expected no outstanding instruction (t=%0t)", $time);
                end else begin
                    logic [CNT_W:0] e;
                    e = expQ.pop_front();
                    chk("commit_reg_write", 32'(reg_write), 32'(e[CNT_W]));
                    chk("commit_instret", 32'(instret), 32'(e[CNT_W-1:0]));
                end
            end else begin
                chk("reg_write_outside_wb", 32'(reg_write), 32'(1'b0));
            end
        end
    end

    task automatic doReset();
        rst = 1'b1;
        ifu_done = 1'b0;
        idu_is_ls = 1'b0;
        idu_rd_wen = 1'b0;
        idu_ebreak = 1'b0;
        lsu_done = 1'b0;
        expQ.delete();
        step();
        step();
        @(negedge clk);
        rst = 1'b0;
        expInstret = '0;
        step();
        chk("post_reset_state", 32'(state_o), 32'(ST_IF));
    endtask

    // Entered and left with the sequencer in S_IF, 1 ns after a rising edge.
    task automatic runInst(input logic isLs, input logic rdWen, input int ifWait, input int lsWait);
        expQ.push_back({rdWen, expInstret});
        expInstret = expInstret + 1'b1;
        for (int i = 0; i < ifWait; i++) begin
            lsu_done = 1'b1;
            chk("if_wait_state", 32'(state_o), 32'(ST_IF));
            step();
        end
        lsu_done = 1'b0;
        chk("if_state", 32'(state_o), 32'(ST_IF));
        chk("if_req", 32'(ifu_req), 32'(1'b1));
        ifu_done = 1'b1;
        idu_is_ls = isLs;
        idu_rd_wen = rdWen;
        idu_ebreak = 1'b0;
        step();
        ifu_done = 1'b0;
        chk("id_state", 32'(state_o), 32'(ST_ID));
        chk("id_no_ifu_req", 32'(ifu_req), 32'(1'b0));
        step();
        if (isLs) begin
            for (int i = 0; i < lsWait; i++) begin
                chk("ls_state", 32'(state_o), 32'(ST_LS));
                chk("ls_req", 32'(lsu_req), 32'(1'b1));
                ifu_done = 1'b1;
                if (i == lsWait - 1) lsu_done = 1'b1;
                step();
            end
            lsu_done = 1'b0;
            ifu_done = 1'b0;
        end
        chk("wb_state", 32'(state_o), 32'(ST_WB));
        chk("wb_pc_update", 32'(pc_update), 32'(1'b1));
        chk("wb_no_lsu_req", 32'(lsu_req), 32'(1'b0));
        step();
        chk("wb_to_if", 32'(state_o), 32'(ST_IF));
        chk("pc_update_one_cycle", 32'(pc_update), 32'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state_o), 32'(ST_RST));
        chk("rst_ifu_req", 32'(ifu_req), 32'(1'b0));
        chk("rst_lsu_req", 32'(lsu_req), 32'(1'b0));
        chk("rst_pc_update", 32'(pc_update), 32'(1'b0));
        chk("rst_halted", 32'(halted), 32'(1'b0));
        chk("rst_bus_err", 32'(bus_err), 32'(1'b0));
        chk("rst_instret", 32'(instret), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("first_if", 32'(state_o), 32'(ST_IF));

        // ALU with rd write, 1-cycle fetch
        runInst(1'b0, 1'b1, 0, 0);
        chk("instret_after_alu", 32'(instret), 32'(1));
        // Store, LSU done after 3 cycles
        runInst(1'b1, 1'b0, 0, 3);
        chk("instret_after_store", 32'(instret), 32'(2));
        // Load with a slow fetch and 1-cycle LSU
        runInst(1'b1, 1'b1, 2, 1);
        // ALU without rd write
        runInst(1'b0, 1'b0, 3, 0);
        chk("instret_after_four", 32'(instret), 32'(4));
`ifndef CTRL_TIMEOUT_EN
        // Long waits must not error without the watchdog
        runInst(1'b1, 1'b1, 40, 40);
        chk("no_bus_err", 32'(bus_err), 32'(1'b0));
`endif

        // Reset in the middle of a memory access
        ifu_done = 1'b1;
        idu_is_ls = 1'b1;
        idu_rd_wen = 1'b1;
        step();
        ifu_done = 1'b0;
        step();
        step();
        chk("mid_ls_state", 32'(state_o), 32'(ST_LS));
        chk("mid_ls_req", 32'(lsu_req), 32'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(state_o), 32'(ST_RST));
        chk("async_rst_lsu_req", 32'(lsu_req), 32'(1'b0));
        chk("async_rst_instret", 32'(instret), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        idu_is_ls = 1'b0;
        idu_rd_wen = 1'b0;
        expInstret = '0;
        step();
        chk("after_async_rst_if", 32'(state_o), 32'(ST_IF));

        // Two retirements, then ebreak (with is_ls also set) halts
        runInst(1'b0, 1'b1, 0, 0);
        runInst(1'b1, 1'b1, 1, 2);
        ifu_done = 1'b1;
        idu_ebreak = 1'b1;
        idu_is_ls = 1'b1;
        step();
        ifu_done = 1'b0;
        chk("ebreak_id", 32'(state_o), 32'(ST_ID));
        step();
        for (int i = 0; i < 100; i++) begin
            chk("halt_state", 32'(state_o), 32'(ST_HALT));
            chk("halt_flag", 32'(halted), 32'(1'b1));
            chk("halt_instret", 32'(instret), 32'(2));
            ifu_done = (i % 2 == 0);
            lsu_done = (i % 3 == 0);
            step();
        end
        ifu_done = 1'b0;
        lsu_done = 1'b0;
        chk("halt_no_ifu_req", 32'(ifu_req), 32'(1'b0));

        // 17 retirements on a 4-bit counter wrap to 1
        doReset();
        for (int i = 0; i < 17; i++) begin
            runInst((i % 3 == 0), (i % 2 == 1), i % 2, 1 + (i % 2));
        end
        chk("instret_wrap", 32'(instret), 32'(1));

`ifdef CTRL_TIMEOUT_EN
        // Fetch never completes: error after the 9th S_IF cycle
        doReset();
        repeat (8) step();
        chk("to_ninth_if", 32'(state_o), 32'(ST_IF));
        chk("to_no_err_yet", 32'(bus_err), 32'(1'b0));
        step();
        chk("to_err_state", 32'(state_o), 32'(ST_ERR));
        chk("to_bus_err", 32'(bus_err), 32'(1'b1));
        ifu_done = 1'b1;
        repeat (3) step();
        ifu_done = 1'b0;
        chk("to_err_terminal", 32'(state_o), 32'(ST_ERR));
        // Done on the 9th S_IF cycle wins over expiry
        doReset();
        repeat (8) step();
        ifu_done = 1'b1;
        step();
        ifu_done = 1'b0;
        chk("to_done_wins", 32'(state_o), 32'(ST_ID));
        chk("to_done_no_err", 32'(bus_err), 32'(1'b0));
        // LSU never completes: error after the 9th S_LS cycle
        idu_is_ls = 1'b1;
        step();
        repeat (8) step();
        chk("to_ninth_ls", 32'(state_o), 32'(ST_LS));
        step();
        chk("to_ls_err", 32'(state_o), 32'(ST_ERR));
        doReset();
`endif

        chk("queue_drained", 32'(expQ.size()), 32'(0));
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
